// File: rtl/key_cmd_scheduler.sv
// Merges debounced key pulses and auto-repeat ticks into one prioritized
// command stream, buffered in a small FWFT FIFO with a valid/ready handshake.
module key_cmd_scheduler #(
    parameter int unsigned REPEAT_DELAY  = 30_000_000,
    parameter int unsigned REPEAT_PERIOD = 10_000_000,
    parameter logic [4:0]  REPEAT_MASK   = 5'b01011,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [4:0]                    key_pulse,
    input  logic [4:0]                    key_n,
    output logic                          cmd_valid,
    output logic [2:0]                    cmd_code,
    input  logic                          cmd_ready,
    output logic                          cmd_dropped,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, WAIT, RPT} rpt_state_t;

    logic [4:0]       key_sync1, key_sync2, held;
    rpt_state_t       state [5];
    logic [31:0]      cnt [5];
    logic [4:0]       tick, events, pend, grant_mask;
    logic [2:0]       grant_idx;
    logic             grant_any, push_ok, pop, full;
    logic [2:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    // Raw levels are asynchronous; presetting to 1 means "released" after reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_sync1 <= '1;
            key_sync2 <= '1;
        end else begin
            key_sync1 <= key_n;
            key_sync2 <= key_sync1;
        end
    end

    assign held = ~key_sync2;

    // Release and a fresh pulse both take precedence over a repeat tick.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        tick = '0;
        for (int i = 0; i < 5; i++) begin
            if (REPEAT_MASK[i] && held[i] && !key_pulse[i]) begin
                if (state[i] == WAIT && cnt[i] == 32'(REPEAT_DELAY - 1))
                    tick[i] = 1'b1;
                if (state[i] == RPT && cnt[i] == 32'(REPEAT_PERIOD - 1))
                    tick[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (!REPEAT_MASK[i]) begin
                    state[i] <= IDLE;
                    cnt[i]   <= '0;
                end else begin
                    case (state[i])
                        IDLE: begin
                            if (key_pulse[i] && held[i]) begin
                                state[i] <= WAIT;
                                cnt[i]   <= '0;
                            end
                        end
                        WAIT, RPT: begin
                            if (!held[i]) begin
                                state[i] <= IDLE;
                                cnt[i]   <= '0;
                            end else if (key_pulse[i]) begin
                                state[i] <= WAIT;
                                cnt[i]   <= '0;
                            end else if (tick[i]) begin
                                state[i] <= RPT;
                                cnt[i]   <= '0;
                            end else begin
                                cnt[i] <= cnt[i] + 32'd1;
                            end
                        end
                        default: begin
                            state[i] <= IDLE;
                            cnt[i]   <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign events    = key_pulse | tick;
    assign cmd_valid = (fifo_level != '0);
    assign pop       = cmd_valid & cmd_ready;
    assign full      = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign push_ok   = ~full | pop;

    // Fixed priority: hard-drop, rotate, left, right, soft-down.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 3'd0;
        if (push_ok) begin
            grant_any = 1'b1;
            if      (pend[4]) grant_idx = 3'd4;
            else if (pend[2]) grant_idx = 3'd2;
            else if (pend[0]) grant_idx = 3'd0;
            else if (pend[1]) grant_idx = 3'd1;
            else if (pend[3]) grant_idx = 3'd3;
            else              grant_any = 1'b0;
        end
    end

    assign grant_mask = grant_any ? (5'b00001 << grant_idx) : 5'b00000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend        <= '0;
            cmd_dropped <= 1'b0;
        end else begin
            pend <= (pend & ~grant_mask) | events;
            if (|(events & pend & ~grant_mask))
                cmd_dropped <= 1'b1;
        end
    end

    // NOTE: FIFO storage has no reset; its contents only matter where cmd_valid qualifies them.
    always_ff @(posedge clk) begin
        if (grant_any)
            mem[wr_ptr] <= grant_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (grant_any)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({grant_any, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    assign cmd_code = cmd_valid ? mem[rd_ptr] : 3'd0;

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Bench for key_cmd_scheduler: directed scenarios plus random traffic, all
// compared cycle by cycle against a timestamp/queue based reference model.
module tb_key_cmd_scheduler;

    localparam int unsigned DELAY  = 8;
    localparam int unsigned PERIOD = 4;
    localparam int unsigned DEPTH  = 4;
    localparam logic [4:0]  MASK   = 5'b01011;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] key_pulse = '0;
    logic [4:0] key_n = '1;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic       cmd_ready = 1'b0;
    logic       cmd_dropped;
    logic [2:0] fifo_level;

    key_cmd_scheduler #(
        .REPEAT_DELAY (DELAY),
        .REPEAT_PERIOD(PERIOD),
        .REPEAT_MASK  (MASK),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_pulse  (key_pulse),
        .key_n      (key_n),
        .cmd_valid  (cmd_valid),
        .cmd_code   (cmd_code),
        .cmd_ready  (cmd_ready),
        .cmd_dropped(cmd_dropped),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending set, command queue, absolute tick deadlines.
    bit [4:0] m_pend;
    int       m_q[$];
    bit       m_drop;
    bit [4:0] m_kn1, m_kn2;
    bit       m_active[5];
    longint   m_next[5];
    longint   m_edge;
    int       pops[$];

    function automatic void model_reset();
        m_pend = '0;
        m_q.delete();
        m_drop = 1'b0;
        m_kn1  = '1;
        m_kn2  = '1;
        for (int i = 0; i < 5; i++) begin
            m_active[i] = 1'b0;
            m_next[i]   = 0;
        end
        m_edge = 0;
    endfunction

    function automatic void model_step(input logic [4:0] kp, input logic [4:0] kn, input logic rdy);
        int       order[5] = '{4, 2, 0, 1, 3};
        bit [4:0] held;
        bit [4:0] ev;
        bit       pop;
        int       g;
        held = ~m_kn2;
        g    = -1;
        m_edge++;
        pop = (m_q.size() != 0) && rdy;
        if (m_q.size() < DEPTH || pop)
            for (int k = 0; k < 5; k++)
                if (g < 0 && m_pend[order[k]]) g = order[k];
        for (int i = 0; i < 5; i++) begin
            bit t;
            t = 1'b0;
            if (MASK[i]) begin
                if (!held[i]) m_active[i] = 1'b0;
                else if (kp[i]) begin
                    m_active[i] = 1'b1;
                    m_next[i]   = m_edge + DELAY;
                end else if (m_active[i] && m_edge == m_next[i]) begin
                    t         = 1'b1;
                    m_next[i] = m_edge + PERIOD;
                end
            end
            ev[i] = kp[i] | t;
        end
        for (int i = 0; i < 5; i++) begin
            bit gr;
            gr = (g == i);
            if (ev[i] && m_pend[i] && !gr) m_drop = 1'b1;
            m_pend[i] = (m_pend[i] && !gr) || ev[i];
        end
        if (pop) void'(m_q.pop_front());
        if (g >= 0) m_q.push_back(g);
        m_kn2 = m_kn1;
        m_kn1 = kn;
    endfunction

    task automatic compare_all();
        bit v;
        v = (m_q.size() != 0);
        check("cmd_valid", cmd_valid, v);
        if (v) check("cmd_code", cmd_code, m_q[0]);
        check("cmd_dropped", cmd_dropped, m_drop);
        check("fifo_level", fifo_level, m_q.size());
    endtask

    task automatic step(input logic [4:0] kp, input logic [4:0] kn, input logic rdy);
        @(negedge clk);
        compare_all();
        key_pulse = kp;
        key_n     = kn;
        cmd_ready = rdy;
        if (cmd_valid && rdy) pops.push_back(int'(cmd_code));
        model_step(kp, kn, rdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        key_pulse = '0;
        cmd_ready = 1'b0;
        #1;
        check("rst_valid", cmd_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_dropped", cmd_dropped, 0);
        check("rst_code", cmd_code, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_step(key_pulse, key_n, cmd_ready);
    endtask

    task automatic hold_test(input int key, input int exp_count);
        logic [4:0] kn;
        kn = 5'b11111;
        kn[key] = 1'b0;
        pops.delete();
        repeat (3) step('0, kn, 1'b1);
        step(5'b00001 << key, kn, 1'b1);
        repeat (29) step('0, kn, 1'b1);
        repeat (12) step('0, '1, 1'b1);
        check($sformatf("hold%0d_count", key), pops.size(), exp_count);
        foreach (pops[j]) check($sformatf("hold%0d_code", key), pops[j], key);
    endtask

    initial begin
        int ones;
        logic [4:0] kn_r, kp_r;
        logic rdy_r;
        model_reset();
        do_reset();

        // Single rotate press: one command, code 2, FIFO drains back to empty.
        pops.delete();
        repeat (3) step('0, '1, 1'b1);
        step(5'b00100, '1, 1'b1);
        repeat (6) step('0, '1, 1'b1);
        check("single_count", pops.size(), 1);
        if (pops.size() > 0) check("single_code", pops[0], 2);
        check("single_level", fifo_level, 0);

        // All keys at once with no consumer: FIFO fills, soft-down waits.
        step(5'b11111, '1, 1'b0);
        repeat (5) step('0, '1, 1'b0);
        check("burst_level", fifo_level, 4);
        check("burst_head", cmd_code, 4);
        pops.delete();
        repeat (8) step('0, '1, 1'b1);
        check("burst_count", pops.size(), 5);
        if (pops.size() == 5) begin
            check("burst_ord0", pops[0], 4);
            check("burst_ord1", pops[1], 2);
            check("burst_ord2", pops[2], 0);
            check("burst_ord3", pops[3], 1);
            check("burst_ord4", pops[4], 3);
        end

        // Held left repeats (1 + 6 ticks); held rotate never repeats.
        hold_test(0, 7);
        hold_test(2, 1);

        // Full FIFO: second right press merges into the pending one.
        step(5'b11101, '1, 1'b0);
        repeat (5) step('0, '1, 1'b0);
        check("full_level", fifo_level, 4);
        step(5'b00010, '1, 1'b0);
        step('0, '1, 1'b0);
        check("merge_before", cmd_dropped, 0);
        step(5'b00010, '1, 1'b0);
        step('0, '1, 1'b0);
        check("merge_dropped", cmd_dropped, 1);
        pops.delete();
        repeat (10) step('0, '1, 1'b1);
        ones = 0;
        foreach (pops[j]) if (pops[j] == 1) ones++;
        check("merge_ones", ones, 1);
        check("merge_count", pops.size(), 5);

        // Reset in the middle of a drain with three entries queued.
        step(5'b01111, '1, 1'b0);
        repeat (5) step('0, '1, 1'b0);
        step('0, '1, 1'b1);
        step('0, '1, 1'b0);
        check("pre_rst_level", fifo_level, 3);
        do_reset();
        pops.delete();
        repeat (10) step('0, '1, 1'b1);
        check("post_rst_pops", pops.size(), 0);

        // Random traffic with slow-changing held levels and bursty readiness.
        kn_r = '1;
        for (int c = 0; c < 4000; c++) begin
            if (c == 2000) do_reset();
            for (int b = 0; b < 5; b++) begin
                if ($urandom_range(15) == 0) kn_r[b] = ~kn_r[b];
                kp_r[b] = ($urandom_range(9) == 0);
            end
            if ((c / 300) % 2 == 0) rdy_r = ($urandom_range(3) != 0);
            else                    rdy_r = ($urandom_range(7) == 0);
            step(kp_r, kn_r, rdy_r);
        end
        step('0, '1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/key_cmd_scheduler.md
Name: key_cmd_scheduler

Overview:
- Sits between the five per-button debouncers and the Tetris game FSM.
- Turns one-cycle debounced press pulses into a single ordered stream of game commands.
- Adds auto-repeat for held movement keys and arbitrates simultaneous keys by fixed priority.
- Buffers commands in a small FWFT FIFO with a valid/ready handshake toward the game logic.

Parameters:
REPEAT_DELAY, 30_000_000, cycles from press pulse to first auto-repeat (300 ms @ 100 MHz); legal range >= 2
REPEAT_PERIOD, 10_000_000, cycles between subsequent auto-repeats; legal range >= 2
REPEAT_MASK, 5'b01011, per-key auto-repeat enable (bit i = key i)
FIFO_DEPTH, 4, command FIFO entries; power of 2, >= 2

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
key_pulse  input  5  debounced one-cycle press pulses; index 0 left, 1 right, 2 rotate, 3 soft-down, 4 hard-drop
key_n  input  5  raw button levels, active-low (0 = held), asynchronous to clk
cmd_valid  output  1  FIFO head holds a command
cmd_code  output  3  command = key index 0..4; meaningful only when cmd_valid = 1
cmd_ready  input  1  game FSM accepts the head this cycle
cmd_dropped  output  1  sticky flag: an event coalesced into an already-pending request
fifo_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert; release synchronous to clk):
  - pending cleared, FIFO empty, every repeat FSM in IDLE, counters 0.
  - key_n synchronizers preset to 1 (released).
  - Outputs: cmd_valid 0, cmd_code 0, cmd_dropped 0, fifo_level 0.
  - Reset mid-operation discards all queued and pending commands.
- Sync: key_n passes through 2 flops per bit; held[i] = ~key_n_sync[i].
- Event sources per key i:
  - key_pulse[i] = 1.
  - A repeat tick from key i's repeat FSM.
- Pending flags pend[4:0]:
  - An event sets pend[i].
  - A grant clears it.
  - Event and grant on the same key in the same cycle: pend stays 1 (new event preserved).
  - Event while pend[i] is already 1 and not being granted: request merges and cmd_dropped <= 1 (sticky until rst).
- Repeat FSM per key, active only when REPEAT_MASK[i] = 1 (otherwise always IDLE). 32-bit counter cnt.
  - IDLE: key_pulse[i] & held[i] -> WAIT, cnt <= 0.
  - WAIT:
    - ~held[i] -> IDLE.
    - cnt == REPEAT_DELAY-1 -> tick, go to RPT, cnt <= 0.
    - otherwise cnt++.
  - RPT:
    - ~held[i] -> IDLE.
    - cnt == REPEAT_PERIOD-1 -> tick, cnt <= 0.
    - otherwise cnt++.
  - key_pulse[i] in WAIT or RPT restarts WAIT with cnt <= 0; the pulse is still an event.
  - Release has priority over tick in the same cycle: no tick is generated.
- Arbiter:
  - Each cycle, grants at most one pending key, if push_ok = (fifo_level < FIFO_DEPTH) | pop.
  - pop = cmd_valid & cmd_ready.
  - Fixed priority: 4 > 2 > 0 > 1 > 3.
  - The granted index is written to the FIFO tail at the same edge its pend bit clears.
- FIFO:
  - First-word fall-through; cmd_valid = (fifo_level != 0); cmd_code = head.
  - Push and pop in the same cycle: level unchanged, also when full.
  - Pointers wrap modulo FIFO_DEPTH.
  - cmd_code holds its value while cmd_valid = 1 and cmd_ready = 0.
- Latency: pulse at edge k sets pend; grant at edge k+1; cmd_valid = 1 after edge k+1 (2 cycles, empty FIFO, no higher-priority pending).
- Full FIFO with no pop: no grant, pend bits hold. Nothing is lost except merges counted by cmd_dropped.

Test Plan (REPEAT_DELAY = 8, REPEAT_PERIOD = 4 unless noted):
- Reset then idle, cmd_ready = 1; single key_pulse[2] at edge 10 -> cmd_valid = 1 for exactly 1 cycle after edge 11, cmd_code = 2; fifo_level returns to 0.
- key_pulse = 5'b11111 in one cycle, cmd_ready = 0 -> fifo_level climbs 1,2,3,4 with entries 4,2,0,1; pend[3] held. Then assert cmd_ready -> codes drain in order 4,2,0,1,3.
- key_n[0] low with pulse, held 30 cycles -> ticks 8 cycles after pulse, then every 4 cycles. Outputs code 0 at pulse+2, then every 4 cycles. Release -> no further commands.
- key_n[2] held 30 cycles after pulse (REPEAT_MASK bit 2 = 0) -> exactly one code-2 command.
- FIFO full, cmd_ready = 0; key_pulse[1] twice -> second pulse sets cmd_dropped = 1. After drain, only one code 1 is emitted.
- rst asserted mid-drain with fifo_level = 3 -> immediately cmd_valid = 0, fifo_level = 0, cmd_dropped = 0. No stale commands after release.
